// File: rtl/lui_issue_buffer.sv
// lui_issue_buffer: EX-stage LUI result builder with a 2-entry skid buffer feeding the LUI pipeline register
// Ports:
//   Clock, Reset            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       ID handshake; in_imm, in_rt, in_is_lui carry the request
//   flush                   drops every buffered entry at the next edge
//   out_ready/out_valid     downstream handshake; out_data/out_rt present the head entry
//   out_we, out_tick        strobes for the downstream register, raised only when a LUI pops
//   lui_count               saturating count of retired LUIs
module lui_issue_buffer #(
  parameter int NrOfBits = 32,
  parameter int ImmBits  = 16,
  parameter int CntBits  = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ImmBits-1:0]  in_imm,
  input  logic [4:0]          in_rt,
  input  logic                in_is_lui,
  input  logic                flush,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [NrOfBits-1:0] out_data,
  output logic [4:0]          out_rt,
  output logic                out_we,
  output logic                out_tick,
  output logic [CntBits-1:0]  lui_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic rdy_q, push, pop, head_lui, sec_lui;
  logic [NrOfBits-1:0] new_data, sec_data;
  logic [4:0] sec_rt;
  logic load_new, load_sec, load_skid;
  // Shift form keeps the zero fill legal even when NrOfBits == ImmBits.
  assign new_data = NrOfBits'(in_imm) << (NrOfBits - ImmBits);
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
    end
  always_comb
    state_d = flush              ? EMPTY :
              (state_q == EMPTY) ? (push ? ONE : EMPTY) :
              (state_q == ONE)   ? ((push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE) :
                                   (pop ? ONE : FULL);
  always_comb begin
    out_valid = state_q != EMPTY;
    in_ready  = rdy_q && state_q != FULL && !flush;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_we    = pop && head_lui;
    out_tick  = out_we;
  end
  // The head lives directly in the output registers so it holds its last value when empty.
  assign load_new  = !flush && push && (state_q == EMPTY || pop);
  assign load_sec  = !flush && pop && state_q == FULL;
  assign load_skid = !flush && push && !pop && state_q == ONE;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      out_data  <= '0;
      out_rt    <= '0;
      head_lui  <= 1'b0;
      sec_data  <= '0;
      sec_rt    <= '0;
      sec_lui   <= 1'b0;
      lui_count <= '0;
    end else begin
      if (load_new) begin
        out_data <= new_data;
        out_rt   <= in_rt;
        head_lui <= in_is_lui;
      end else if (load_sec) begin
        out_data <= sec_data;
        out_rt   <= sec_rt;
        head_lui <= sec_lui;
      end
      if (load_skid) begin
        sec_data <= new_data;
        sec_rt   <= in_rt;
        sec_lui  <= in_is_lui;
      end
      if (out_we && lui_count != '1)
        lui_count <= lui_count + CntBits'(1);
    end
endmodule

// File: tb/tb_lui_issue_buffer.sv
// tb_lui_issue_buffer: table-driven check of lui_issue_buffer plus reset and saturation sequences
module tb_lui_issue_buffer;
  logic Clock = 1'b0, Reset;
  logic in_valid, in_is_lui, flush, out_ready;
  logic [15:0] in_imm;
  logic [4:0] in_rt;
  logic in_ready, out_valid, out_we, out_tick;
  logic [31:0] out_data;
  logic [4:0] out_rt;
  logic [15:0] lui_count;
  logic s_in_ready, s_out_valid, s_out_we, s_out_tick;
  logic [31:0] s_out_data;
  logic [4:0] s_out_rt;
  logic [1:0] s_cnt;
  int errors = 0, checks = 0;

  always #5 Clock = ~Clock;

  lui_issue_buffer dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_rt(in_rt), .in_is_lui(in_is_lui), .flush(flush),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .out_rt(out_rt),
    .out_we(out_we), .out_tick(out_tick), .lui_count(lui_count));

  lui_issue_buffer #(.CntBits(2)) u_sat (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_imm(in_imm), .in_rt(in_rt), .in_is_lui(in_is_lui), .flush(flush),
    .out_ready(out_ready), .out_valid(s_out_valid), .out_data(s_out_data), .out_rt(s_out_rt),
    .out_we(s_out_we), .out_tick(s_out_tick), .lui_count(s_cnt));

  typedef struct {
    logic        vld;
    logic [15:0] imm;
    logic [4:0]  rt;
    logic        lui;
    logic        fl;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [4:0]  e_rt;
    logic        e_we;
    logic [15:0] e_cnt;
  } vec_t;
  vec_t v[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [15:0] imm, input logic [4:0] rt,
                       input logic lui, input logic fl, input logic ordy);
    in_valid = vld; in_imm = imm; in_rt = rt; in_is_lui = lui; flush = fl; out_ready = ordy;
  endtask

  initial begin
    // vld imm rt lui fl ordy | rdy ov data rt we cnt   (checked at the negedge before the edge)
    v[0]  = '{1, 16'h1234,  5, 1, 0, 1, 1, 0, 32'h0000_0000,  0, 0, 0};
    v[1]  = '{0, 16'h0000,  0, 0, 0, 1, 1, 1, 32'h1234_0000,  5, 1, 0};
    v[2]  = '{0, 16'h0000,  0, 0, 0, 0, 1, 0, 32'h1234_0000,  5, 0, 1};
    v[3]  = '{1, 16'h0001,  1, 1, 0, 0, 1, 0, 32'h1234_0000,  5, 0, 1};
    v[4]  = '{1, 16'h0002,  2, 1, 0, 0, 1, 1, 32'h0001_0000,  1, 0, 1};
    v[5]  = '{1, 16'h0003,  3, 1, 0, 0, 0, 1, 32'h0001_0000,  1, 0, 1};
    v[6]  = '{1, 16'h0003,  3, 1, 0, 1, 0, 1, 32'h0001_0000,  1, 1, 1};
    v[7]  = '{1, 16'h0003,  3, 1, 0, 1, 1, 1, 32'h0002_0000,  2, 1, 2};
    v[8]  = '{0, 16'h0000,  0, 0, 0, 1, 1, 1, 32'h0003_0000,  3, 1, 3};
    v[9]  = '{1, 16'hABCD,  7, 0, 0, 1, 1, 0, 32'h0003_0000,  3, 0, 4};
    v[10] = '{1, 16'hFFFF,  9, 1, 0, 1, 1, 1, 32'hABCD_0000,  7, 0, 4};
    v[11] = '{0, 16'h0000,  0, 0, 0, 1, 1, 1, 32'hFFFF_0000,  9, 1, 4};
    v[12] = '{0, 16'h0000,  0, 0, 0, 1, 1, 0, 32'hFFFF_0000,  9, 0, 5};
    v[13] = '{1, 16'h0011, 11, 1, 0, 0, 1, 0, 32'hFFFF_0000,  9, 0, 5};
    v[14] = '{1, 16'h0022, 12, 1, 0, 0, 1, 1, 32'h0011_0000, 11, 0, 5};
    v[15] = '{1, 16'h0033, 13, 1, 1, 1, 0, 1, 32'h0011_0000, 11, 1, 5};
    v[16] = '{0, 16'h0000,  0, 0, 0, 1, 1, 0, 32'h0011_0000, 11, 0, 6};
    v[17] = '{1, 16'h0044, 14, 1, 0, 1, 1, 0, 32'h0011_0000, 11, 0, 6};
    v[18] = '{0, 16'h0000,  0, 0, 0, 1, 1, 1, 32'h0044_0000, 14, 1, 6};
    v[19] = '{1, 16'h0055, 15, 1, 0, 0, 1, 0, 32'h0044_0000, 14, 0, 7};
    v[20] = '{0, 16'h0000,  0, 0, 1, 0, 0, 1, 32'h0055_0000, 15, 0, 7};
    v[21] = '{0, 16'h0000,  0, 0, 0, 1, 1, 0, 32'h0055_0000, 15, 0, 7};

    Reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_rt", out_rt, 0);
    chk("reset_out_we", out_we, 0);
    chk("reset_lui_count", lui_count, 0);
    @(negedge Clock);
    Reset = 1'b1;
    #1 chk("ready_before_first_edge", in_ready, 0);
    @(posedge Clock); #1;
    chk("ready_after_release", in_ready, 1);

    for (int i = 0; i < 22; i++) begin
      drive(v[i].vld, v[i].imm, v[i].rt, v[i].lui, v[i].fl, v[i].ordy);
      @(negedge Clock);
      chk($sformatf("v%0d_in_ready", i), in_ready, v[i].e_rdy);
      chk($sformatf("v%0d_out_valid", i), out_valid, v[i].e_ov);
      chk($sformatf("v%0d_out_data", i), out_data, v[i].e_data);
      chk($sformatf("v%0d_out_rt", i), out_rt, v[i].e_rt);
      chk($sformatf("v%0d_out_we", i), out_we, v[i].e_we);
      chk($sformatf("v%0d_out_tick", i), out_tick, v[i].e_we);
      chk($sformatf("v%0d_lui_count", i), lui_count, v[i].e_cnt);
      chk($sformatf("v%0d_sat_count", i), s_cnt, (v[i].e_cnt > 3) ? 32'd3 : 32'(v[i].e_cnt));
      @(posedge Clock); #1;
    end

    // Fill the buffer, then assert Reset between edges with a LUI about to retire.
    drive(1, 16'h0066, 1, 1, 0, 0);
    @(posedge Clock); #1;
    drive(1, 16'h0077, 2, 1, 0, 0);
    @(posedge Clock); #1;
    drive(0, 0, 0, 0, 0, 1);
    #1 chk("full_in_ready", in_ready, 0);
    chk("full_out_we", out_we, 1);
    chk("full_head_data", out_data, 32'h0066_0000);
    Reset = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_we", out_we, 0);
    chk("async_out_tick", out_tick, 0);
    chk("async_lui_count", lui_count, 0);
    chk("async_sat_count", s_cnt, 0);
    chk("async_out_data", out_data, 0);
    chk("async_in_ready", in_ready, 0);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    drive(1, 16'h8888, 3, 1, 0, 1);
    @(negedge Clock);
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_no_comb_path", out_valid, 0);
    @(posedge Clock); #1;
    drive(0, 0, 0, 0, 0, 1);
    @(negedge Clock);
    chk("post_reset_out_valid", out_valid, 1);
    chk("post_reset_out_data", out_data, 32'h8888_0000);
    chk("post_reset_out_rt", out_rt, 3);
    chk("post_reset_out_we", out_we, 1);
    @(posedge Clock); #1;
    chk("post_reset_lui_count", lui_count, 1);
    chk("post_reset_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
